// File: rtl/conv_row_sequencer.sv
// Row sequencer for a PE grid: gathers weight and image elements from ready/valid
// streams into lane buffers and broadcasts each completed row in one issue cycle.
module conv_row_sequencer #(
    parameter int DATA_W       = 16,
    parameter int GRID_COLS    = 14,
    parameter int GRID_ROWS    = 12,
    parameter int TAG_W        = 4,
    parameter int DIM_W        = 8,
    parameter int GAP_CYCLES   = 1,
    parameter int DRAIN_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [TAG_W:0]              cfg_k_rows,
    input  logic [DIM_W-1:0]            cfg_k_cols,
    input  logic [DIM_W-1:0]            cfg_img_rows,
    input  logic [DIM_W-1:0]            cfg_img_cols,
    input  logic [DATA_W-1:0]           w_data,
    input  logic                        w_valid,
    output logic                        w_ready,
    input  logic [DATA_W-1:0]           x_data,
    input  logic                        x_valid,
    output logic                        x_ready,
    output logic [GRID_COLS*DATA_W-1:0] row_weight_vals,
    output logic [TAG_W-1:0]            tag_row,
    output logic                        valid_y,
    output logic [GRID_COLS*DATA_W-1:0] image_val_vec,
    output logic [GRID_COLS-1:0]        valid_x_vec,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [3:0]                  dbg_state
);

    // Handshake: an element moves on a rising edge where valid=1 and ready=1 and
    // abort=0. Ready is a registered copy of "in the matching LOAD state", so it
    // drops the cycle after a row's last element and the next element waits.

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_CHECK   = 4'd1,
        ST_LOAD_W  = 4'd2,
        ST_ISSUE_W = 4'd3,
        ST_GAP_W   = 4'd4,
        ST_LOAD_X  = 4'd5,
        ST_ISSUE_X = 4'd6,
        ST_GAP_X   = 4'd7,
        ST_DRAIN   = 4'd8,
        ST_DONE    = 4'd9
    } state_t;

    // The drain window is measured from the last image issue, so it includes that row's gap.
    localparam int DRAIN_REM = (DRAIN_CYCLES > GAP_CYCLES) ? DRAIN_CYCLES - GAP_CYCLES : 0;
    localparam int WAIT_MAX  = (GAP_CYCLES > DRAIN_REM) ? GAP_CYCLES : DRAIN_REM;
    localparam int WAIT_W    = $clog2(WAIT_MAX + 1);

    localparam logic [WAIT_W-1:0] GAP_LAST   = WAIT_W'(GAP_CYCLES - 1);
    localparam logic [WAIT_W-1:0] DRAIN_LAST = WAIT_W'((DRAIN_REM > 0) ? DRAIN_REM - 1 : 0);
    localparam logic [DIM_W-1:0]  COLS_MAX   = DIM_W'(GRID_COLS);
    localparam logic [TAG_W:0]    KROWS_MAX  = (TAG_W + 1)'(GRID_ROWS);
    localparam logic [DIM_W-1:0]  ONE        = DIM_W'(1);

    state_t state, state_d;

    logic [DIM_W-1:0]  row, row_d;
    logic [DIM_W-1:0]  col, col_d;
    logic [DIM_W-1:0]  row_inc;
    logic [WAIT_W-1:0] wait_cnt, wait_d;

    logic [TAG_W:0]    k_rows_q;
    logic [DIM_W-1:0]  k_cols_q;
    logic [DIM_W-1:0]  img_rows_q;
    logic [DIM_W-1:0]  img_cols_q;

    logic [GRID_COLS*DATA_W-1:0] wlanes_d;
    logic [GRID_COLS*DATA_W-1:0] xlanes_d;
    logic [GRID_COLS-1:0]        vx_mask;
    logic                        cfg_bad;
    logic                        err_d;
    logic                        w_fire;
    logic                        x_fire;

    assign row_inc   = row + ONE;
    assign w_fire    = w_valid && w_ready;
    assign x_fire    = x_valid && x_ready;
    assign dbg_state = state;

    assign cfg_bad = (k_rows_q == '0) || (k_cols_q == '0) ||
                     (img_rows_q == '0) || (img_cols_q == '0) ||
                     (k_cols_q > COLS_MAX) || (img_cols_q > COLS_MAX) ||
                     (k_rows_q > KROWS_MAX);

    always_comb begin
        vx_mask = '0;
        for (int c = 0; c < GRID_COLS; c++) begin
            vx_mask[c] = (DIM_W'(c) < img_cols_q);
        end
    end

    always_comb begin
        state_d  = state;
        row_d    = row;
        col_d    = col;
        wait_d   = wait_cnt;
        wlanes_d = row_weight_vals;
        xlanes_d = image_val_vec;
        err_d    = 1'b0;

        if (abort && (state != ST_IDLE)) begin
            state_d = ST_IDLE;
            row_d   = '0;
            col_d   = '0;
            wait_d  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    row_d = '0;
                    col_d = '0;
                    if (cfg_bad) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_LOAD_W;
                    end
                end

                ST_LOAD_W: begin
                    if (w_fire) begin
                        // The first element of a row wipes stale lanes from earlier rows or jobs.
                        if (col == '0) begin
                            wlanes_d = '0;
                        end
                        for (int c = 0; c < GRID_COLS; c++) begin
                            if (col == DIM_W'(c)) begin
                                wlanes_d[c*DATA_W +: DATA_W] = w_data;
                            end
                        end
                        if (col == k_cols_q - ONE) begin
                            col_d   = '0;
                            state_d = ST_ISSUE_W;
                        end else begin
                            col_d = col + ONE;
                        end
                    end
                end

                ST_ISSUE_W: begin
                    wait_d  = '0;
                    state_d = ST_GAP_W;
                end

                ST_GAP_W: begin
                    if (wait_cnt == GAP_LAST) begin
                        wait_d = '0;
                        if (row_inc < DIM_W'(k_rows_q)) begin
                            row_d    = row_inc;
                            col_d    = '0;
                            wlanes_d = '0;
                            state_d  = ST_LOAD_W;
                        end else begin
                            row_d   = '0;
                            col_d   = '0;
                            state_d = ST_LOAD_X;
                        end
                    end else begin
                        wait_d = wait_cnt + WAIT_W'(1);
                    end
                end

                ST_LOAD_X: begin
                    if (x_fire) begin
                        if (col == '0) begin
                            xlanes_d = '0;
                        end
                        for (int c = 0; c < GRID_COLS; c++) begin
                            if (col == DIM_W'(c)) begin
                                xlanes_d[c*DATA_W +: DATA_W] = x_data;
                            end
                        end
                        if (col == img_cols_q - ONE) begin
                            col_d   = '0;
                            state_d = ST_ISSUE_X;
                        end else begin
                            col_d = col + ONE;
                        end
                    end
                end

                ST_ISSUE_X: begin
                    wait_d  = '0;
                    state_d = ST_GAP_X;
                end

                ST_GAP_X: begin
                    if (wait_cnt == GAP_LAST) begin
                        wait_d = '0;
                        if (row_inc < img_rows_q) begin
                            row_d    = row_inc;
                            col_d    = '0;
                            xlanes_d = '0;
                            state_d  = ST_LOAD_X;
                        end else begin
                            row_d   = '0;
                            col_d   = '0;
                            state_d = (DRAIN_REM > 0) ? ST_DRAIN : ST_DONE;
                        end
                    end else begin
                        wait_d = wait_cnt + WAIT_W'(1);
                    end
                end

                ST_DRAIN: begin
                    if (wait_cnt == DRAIN_LAST) begin
                        wait_d  = '0;
                        state_d = ST_DONE;
                    end else begin
                        wait_d = wait_cnt + WAIT_W'(1);
                    end
                end

                ST_DONE: begin
                    state_d = ST_IDLE;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Every output is a flop loaded from the next-state decode, so it lines up with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= ST_IDLE;
            row             <= '0;
            col             <= '0;
            wait_cnt        <= '0;
            k_rows_q        <= '0;
            k_cols_q        <= '0;
            img_rows_q      <= '0;
            img_cols_q      <= '0;
            row_weight_vals <= '0;
            image_val_vec   <= '0;
            tag_row         <= '0;
            valid_y         <= 1'b0;
            valid_x_vec     <= '0;
            w_ready         <= 1'b0;
            x_ready         <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
        end else begin
            state    <= state_d;
            row      <= row_d;
            col      <= col_d;
            wait_cnt <= wait_d;

            if ((state == ST_IDLE) && (state_d == ST_CHECK)) begin
                k_rows_q   <= cfg_k_rows;
                k_cols_q   <= cfg_k_cols;
                img_rows_q <= cfg_img_rows;
                img_cols_q <= cfg_img_cols;
            end

            row_weight_vals <= wlanes_d;
            image_val_vec   <= xlanes_d;

            if (state_d == ST_ISSUE_W) begin
                tag_row <= row_d[TAG_W-1:0];
            end

            valid_y     <= (state_d == ST_ISSUE_W);
            valid_x_vec <= (state_d == ST_ISSUE_X) ? vx_mask : '0;
            w_ready     <= (state_d == ST_LOAD_W);
            x_ready     <= (state_d == ST_LOAD_X);
            busy        <= (state_d != ST_IDLE) && (state_d != ST_DONE);
            done        <= (state_d == ST_DONE);
            err         <= err_d;
        end
    end

endmodule

// File: tb/tb_conv_row_sequencer.sv
// Directed bench for conv_row_sequencer: row issues are predicted into queues as
// stimulus is driven and compared when the grid strobes appear.
`timescale 1ns/1ps
module tb_conv_row_sequencer;

    localparam int DATA_W       = 16;
    localparam int GRID_COLS    = 14;
    localparam int GRID_ROWS    = 12;
    localparam int TAG_W        = 4;
    localparam int DIM_W        = 8;
    localparam int GAP_CYCLES   = 1;
    localparam int DRAIN_CYCLES = 16;
    localparam int LW           = GRID_COLS * DATA_W;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic                  abort = 1'b0;
    logic [TAG_W:0]        cfg_k_rows = '0;
    logic [DIM_W-1:0]      cfg_k_cols = '0;
    logic [DIM_W-1:0]      cfg_img_rows = '0;
    logic [DIM_W-1:0]      cfg_img_cols = '0;
    logic [DATA_W-1:0]     w_data = '0;
    logic                  w_valid = 1'b0;
    logic                  w_ready;
    logic [DATA_W-1:0]     x_data = '0;
    logic                  x_valid = 1'b0;
    logic                  x_ready;
    logic [LW-1:0]         row_weight_vals;
    logic [TAG_W-1:0]      tag_row;
    logic                  valid_y;
    logic [LW-1:0]         image_val_vec;
    logic [GRID_COLS-1:0]  valid_x_vec;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [3:0]            dbg_state;

    conv_row_sequencer #(
        .DATA_W(DATA_W), .GRID_COLS(GRID_COLS), .GRID_ROWS(GRID_ROWS), .TAG_W(TAG_W),
        .DIM_W(DIM_W), .GAP_CYCLES(GAP_CYCLES), .DRAIN_CYCLES(DRAIN_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_k_rows(cfg_k_rows), .cfg_k_cols(cfg_k_cols),
        .cfg_img_rows(cfg_img_rows), .cfg_img_cols(cfg_img_cols),
        .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
        .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
        .row_weight_vals(row_weight_vals), .tag_row(tag_row), .valid_y(valid_y),
        .image_val_vec(image_val_vec), .valid_x_vec(valid_x_vec),
        .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int vectors = 0;
    int miscompares = 0;
    logic [TAG_W+LW-1:0]     exp_w_q[$];
    logic [GRID_COLS+LW-1:0] exp_x_q[$];
    int cur_kr = 0, cur_kc = 0, cur_ir = 0, cur_ic = 0;
    int w_in_row = 0, w_issues = 0, x_in_row = 0, x_issues = 0;
    int last_x_cyc = 0;
    int done_at = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
        end
    endtask

    // Watches the grid side on falling edges; inputs and outputs are both stable there.
    task automatic monitor();
        logic [TAG_W+LW-1:0]     ew;
        logic [GRID_COLS+LW-1:0] ex;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                if (w_ready === 1'b1) begin
                    check("w_ready_legal", ((w_in_row < cur_kc) && (w_issues < cur_kr)), 1'b1);
                    if (w_valid && !abort) w_in_row++;
                end
                if (x_ready === 1'b1) begin
                    check("x_ready_legal", ((w_issues == cur_kr) && (x_in_row < cur_ic) &&
                                            (x_issues < cur_ir)), 1'b1);
                    if (x_valid && !abort) x_in_row++;
                end
                if (valid_y === 1'b1) begin
                    if (exp_w_q.size() == 0) begin
                        check("valid_y_unexpected", valid_y, 1'b0);
                    end else begin
                        ew = exp_w_q.pop_front();
                        check("w_issue", {tag_row, row_weight_vals}, ew);
                    end
                    check("w_issue_elem_count", w_in_row, cur_kc);
                    w_in_row = 0;
                    w_issues++;
                end
                if (valid_x_vec !== '0) begin
                    if (exp_x_q.size() == 0) begin
                        check("valid_x_unexpected", valid_x_vec, 0);
                    end else begin
                        ex = exp_x_q.pop_front();
                        check("x_issue", {valid_x_vec, image_val_vec}, ex);
                    end
                    check("x_issue_elem_count", x_in_row, cur_ic);
                    check("x_issue_no_valid_y", valid_y, 1'b0);
                    x_in_row = 0;
                    x_issues++;
                    last_x_cyc = cyc;
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_w(input logic [DATA_W-1:0] d, input int stall);
        int n = 0;
        w_data  = d;
        w_valid = 1'b1;
        while (w_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) check("w_ready_timeout", w_ready, 1'b1);
        @(posedge clk); #1;
        w_valid = 1'b0;
        repeat (stall) begin @(posedge clk); #1; end
    endtask

    task automatic push_x(input logic [DATA_W-1:0] d, input int stall);
        int n = 0;
        x_data  = d;
        x_valid = 1'b1;
        while (x_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) check("x_ready_timeout", x_ready, 1'b1);
        @(posedge clk); #1;
        x_valid = 1'b0;
        repeat (stall) begin @(posedge clk); #1; end
    endtask

    task automatic clear_job();
        cur_kr = 0; cur_kc = 0; cur_ir = 0; cur_ic = 0;
        exp_w_q.delete();
        exp_x_q.delete();
    endtask

    task automatic start_job(input int kr, input int kc, input int ir, input int ic);
        cfg_k_rows   = (TAG_W + 1)'(kr);
        cfg_k_cols   = DIM_W'(kc);
        cfg_img_rows = DIM_W'(ir);
        cfg_img_cols = DIM_W'(ic);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cur_kr = kr; cur_kc = kc; cur_ir = ir; cur_ic = ic;
        w_in_row = 0; w_issues = 0; x_in_row = 0; x_issues = 0;
        // Config must be ignored once the job is running.
        cfg_k_rows   = (TAG_W + 1)'($urandom);
        cfg_k_cols   = DIM_W'($urandom);
        cfg_img_rows = DIM_W'($urandom);
        cfg_img_cols = DIM_W'($urandom);
        check("busy_after_start", busy, 1'b1);
    endtask

    // mode 0: weights 1 / image 0x0100; mode 1: random data. abort_row < 0 runs to the end.
    task automatic run_job(input int kr, input int kc, input int ir, input int ic,
                           input int ws, input int xs, input int mode, input int abort_row);
        logic [DATA_W-1:0]    rv [GRID_COLS];
        logic [LW-1:0]        lanes;
        logic [GRID_COLS-1:0] m;
        int n;
        int dn;
        start_job(kr, kc, ir, ic);
        for (int r = 0; r < kr; r++) begin
            lanes = '0;
            for (int c = 0; c < kc; c++) begin
                rv[c] = (mode == 0) ? 16'h0001 : DATA_W'($urandom);
                lanes[c*DATA_W +: DATA_W] = rv[c];
            end
            exp_w_q.push_back({TAG_W'(r), lanes});
            for (int c = 0; c < kc; c++) push_w(rv[c], ws);
        end
        for (int r = 0; r < ir; r++) begin
            lanes = '0;
            m = '0;
            for (int c = 0; c < ic; c++) begin
                rv[c] = (mode == 0) ? 16'h0100 : DATA_W'($urandom);
                lanes[c*DATA_W +: DATA_W] = rv[c];
                m[c] = 1'b1;
            end
            exp_x_q.push_back({m, lanes});
            if (r == abort_row) begin
                push_x(rv[0], xs);
                n = 0;
                while (x_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
                x_data  = rv[1];
                x_valid = 1'b1;
                abort   = 1'b1;
                @(posedge clk); #1;
                abort   = 1'b0;
                x_valid = 1'b0;
                check("abort_busy", busy, 1'b0);
                check("abort_x_ready", x_ready, 1'b0);
                check("abort_done", done, 1'b0);
                check("abort_idle", dbg_state, 4'd0);
                clear_job();
                dn = 0;
                repeat (25) begin
                    @(posedge clk); #1;
                    if (done === 1'b1) dn++;
                end
                check("abort_no_done_pulse", dn, 0);
                return;
            end
            for (int c = 0; c < ic; c++) push_x(rv[c], xs);
        end
    endtask

    task automatic wait_done(input string tag, input logic exp_err, output int at);
        int n = 0;
        while (done !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
        at = cyc;
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_busy_at_done"}, busy, 1'b0);
        check({tag, "_queues_drained"}, exp_w_q.size() + exp_x_q.size(), 0);
        @(posedge clk); #1;
        check({tag, "_done_one_cycle"}, {done, err}, 2'b00);
        check({tag, "_idle_after"}, dbg_state, 4'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [DATA_W-1:0] rv [3];
        logic [LW-1:0]     lanes;
        int n;

        fork monitor(); join_none

        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctrl", {w_ready, x_ready, tag_row, valid_y, valid_x_vec, busy, done, err}, 0);
        check("reset_lanes", {row_weight_vals, image_val_vec}, 0);
        check("reset_state", dbg_state, 4'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Happy path, streams always valid.
        run_job(6, 6, 6, 6, 0, 0, 0, -1);
        wait_done("happy", 1'b0, done_at);
        check("happy_done_latency", done_at - last_x_cyc, DRAIN_CYCLES + 1);

        // Backpressure: weights every other cycle, image with 3 idle cycles between.
        run_job(6, 6, 6, 6, 1, 3, 0, -1);
        wait_done("backpressure", 1'b0, done_at);
        check("bp_done_latency", done_at - last_x_cyc, DRAIN_CYCLES + 1);

        // Config error: kernel wider than the grid.
        start_job(2, 15, 2, 2);
        clear_job();
        wait_done("cfg_err", 1'b1, done_at);

        // Abort during the third image row, then a smaller job must run cleanly.
        run_job(6, 6, 6, 6, 0, 0, 1, 2);
        run_job(3, 3, 4, 4, 0, 1, 1, -1);
        wait_done("post_abort", 1'b0, done_at);

        // Asynchronous reset while a weight row is being issued.
        start_job(2, 3, 2, 3);
        lanes = '0;
        for (int c = 0; c < 3; c++) begin
            rv[c] = DATA_W'($urandom);
            lanes[c*DATA_W +: DATA_W] = rv[c];
        end
        exp_w_q.push_back({TAG_W'(0), lanes});
        for (int c = 0; c < 3; c++) push_w(rv[c], 0);
        n = 0;
        while (valid_y !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        check("rst_saw_issue", valid_y, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("rst_async_ctrl", {w_ready, x_ready, tag_row, valid_y, valid_x_vec, busy, done, err}, 0);
        check("rst_async_w_lanes", row_weight_vals, 0);
        check("rst_async_x_lanes", image_val_vec, 0);
        check("rst_async_state", dbg_state, 4'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        clear_job();
        @(posedge clk); #1;

        // Edge sizing: 1x1 kernel, full-width single image row.
        run_job(1, 1, 1, 14, 0, 0, 1, -1);
        wait_done("edge", 1'b0, done_at);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/conv_row_sequencer.md
Name: conv_row_sequencer

Overview:
- Synthesizable controller that feeds PE_Grid_12x14 (and larger grids). It replaces the fixed 6x6 kernel/image load sequence with a runtime-configured, stream-fed sequencer.
- Collects weight and image elements from ready/valid streams into a lane buffer, then issues each row to the grid as a one-cycle broadside.
- Phase order: kernel rows (valid_y/tag_row), then image rows (valid_x_vec), then drain, then a done pulse.

Parameters:
- DATA_W, 16, weight/image element width
- GRID_COLS, 14, grid lanes (columns)
- GRID_ROWS, 12, grid rows; maximum kernel rows
- TAG_W, 4, tag_row width; requires 2**TAG_W >= GRID_ROWS
- DIM_W, 8, width of image-dimension config fields
- GAP_CYCLES, 1, idle cycles after every issue cycle (>=1)
- DRAIN_CYCLES, 16, cycles waited after the last image issue before done

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  begin job; sampled in IDLE only
- abort  in  1  synchronous cancel, any state
- cfg_k_rows  in  TAG_W+1  kernel rows
- cfg_k_cols  in  DIM_W  kernel columns
- cfg_img_rows  in  DIM_W  image rows
- cfg_img_cols  in  DIM_W  image columns
- w_data  in  DATA_W  weight element
- w_valid  in  1  weight valid
- w_ready  out  1  weight ready
- x_data  in  DATA_W  image element
- x_valid  in  1  image valid
- x_ready  out  1  image ready
- row_weight_vals  out  GRID_COLS*DATA_W  lane c at bits [c*DATA_W +: DATA_W]
- tag_row  out  TAG_W  kernel row index of current weight issue
- valid_y  out  1  weight row issue strobe
- image_val_vec  out  GRID_COLS*DATA_W  image lanes, same packing
- valid_x_vec  out  GRID_COLS  per-lane image valid
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle config-error pulse, coincident with done

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- rst low clears all of the following regardless of state:
  - all outputs to 0, including w_ready, x_ready, lane buffers, tag_row, valid_y, valid_x_vec, busy, done and err;
  - the state register to IDLE;
  - all counters.
- All outputs are registered.
- IDLE:
  - start=1 latches the cfg_* fields and sets busy=1 on the next cycle.
  - Config check on latched values. The config is bad if any field is 0, k_cols>GRID_COLS, img_cols>GRID_COLS, or k_rows>GRID_ROWS.
  - Bad config: go to DONE with err=1. No stream is ever made ready.
  - Good config: go to LOAD_W with row=0 and col=0.
- LOAD_W:
  - w_ready=1. Each cycle with w_valid&w_ready writes w_data to lane col, then col++.
  - The k_cols-th accept sets w_ready=0 the following cycle and moves to ISSUE_W.
- ISSUE_W:
  - Exactly one cycle with valid_y=1 and tag_row=row[TAG_W-1:0].
  - row_weight_vals holds the collected lanes. Lanes >= k_cols are 0.
  - Then go to GAP_W.
- GAP_W:
  - GAP_CYCLES cycles with valid_y=0; row_weight_vals is held.
  - If row<k_rows-1: row++, col=0, clear lanes, go to LOAD_W.
  - Otherwise: row=0, go to LOAD_X.
- LOAD_X, ISSUE_X, GAP_X:
  - Same structure as the weight phase, using the x stream, img_cols and img_rows.
  - In ISSUE_X, valid_x_vec[c]=1 for c<img_cols and 0 otherwise, for exactly one cycle. Lanes >= img_cols are 0.
  - valid_y=0 throughout.
  - After the last row's gap, go to DRAIN.
- DRAIN: DRAIN_CYCLES cycles, then DONE.
- DONE:
  - One cycle with done=1 and busy=0 (err=1 only on a config error). Then IDLE.
  - Lane buffers keep their last contents until the next job's first write.
- Ready/valid:
  - A transfer occurs only when valid and ready are both 1.
  - Ready is never asserted outside its LOAD state.
  - Stalls (valid=0) of any length are tolerated; partial rows simply wait.
- Config inputs:
  - Ignored while busy.
  - start while busy, or in DONE, is ignored.
- abort=1 in any non-IDLE state, on the next cycle:
  - IDLE; busy, w_ready, x_ready, valid_y and valid_x_vec go to 0.
  - done does not pulse and counters are cleared.
  - abort in IDLE is a no-op.
  - abort takes priority over start, and over stream transfers in the same cycle; an element offered that cycle is not consumed.
- Simultaneous events: the final accept of a row plus valid on the next element must not consume that next element, because ready drops on the next cycle.
- Counters: row counts 0..rows-1 and col counts 0..cols-1 with no wrap beyond. Counter width must cover DIM_W.

Test Plan:
- Happy path: start with k=6x6, img=6x6, 36 weights of 1, 36 image elements 0x0100, both streams always valid. Required:
  - 6 valid_y pulses with tag_row 0..5, lanes 0..5 = 1 and lanes 6..13 = 0;
  - then 6 valid_x_vec pulses = 14'h003F;
  - done exactly DRAIN_CYCLES+1 cycles after the last x issue; err=0.
- Backpressure: w_valid toggles 1010..., x_valid idle for 3 cycles between elements. Required: same issue values as the happy path, no duplicated or skipped elements, and w_ready/x_ready are never 1 outside their LOAD states.
- Config error: start with cfg_k_cols=15, GRID_COLS=14. Required: done=err=1 together on one cycle; w_ready and x_ready stay 0; back in IDLE afterwards.
- Abort: assert abort during the 3rd image row load. Required: IDLE next cycle, busy=0, no done. A subsequent 3x3/4x4 job completes correctly with tag_row 0..2 and valid_x_vec=14'h000F.
- Reset mid-operation: drive rst low for 1 cycle during ISSUE_W. Required: all outputs 0 immediately and asynchronously; start is accepted normally after release.
- Edge sizing: config 1x1 kernel, image 1x14. Required: one valid_y with lane0 only; one valid_x_vec=14'h3FFF.
